// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped cache tag/valid controller.
package cache_pkg;
    localparam int ADDR_W         = 32;
    localparam int OFFSET_W       = 4;
    localparam int INDEX_W        = 5;
    localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
    localparam int TAGV_VALID_BIT = TAG_W;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOOKUP    = 4'd1,
        INV_PROBE = 4'd2,
        MISS_REQ  = 4'd3,
        MISS_WAIT = 4'd4,
        REFILL_WR = 4'd5,
        INV_WR    = 4'd6,
        RESP      = 4'd7,
        FLUSH     = 4'd8
    } state_e;

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction
endpackage

// File: rtl/cache_tag_cmp.sv
// Combinational hit detect of one {valid, tag} entry against a lookup tag.
module cache_tag_cmp
    import cache_pkg::*;
(
    input  logic [TAG_W:0]   entry,
    input  logic [TAG_W-1:0] tag,
    output logic             hit
);
    assign hit = entry[TAGV_VALID_BIT] && (entry[TAG_W-1:0] == tag);
endmodule

// File: rtl/cache_tagv_ctrl.sv
// Tag/valid array sequencer: lookups, miss refill handshake, invalidation probes, flush.
// Build option TAGV_READ_DELAY_EN: tag array read data lags its address by one cycle.
module cache_tagv_ctrl
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req_valid,
    output logic               cpu_req_ready,
    input  logic [ADDR_W-1:0]  cpu_req_addr,
    output logic               cpu_rsp_valid,
    output logic               cpu_rsp_hit,
    input  logic               inval_valid,
    output logic               inval_ready,
    input  logic [ADDR_W-1:0]  inval_addr,
    input  logic               flush,
    output logic               flush_busy,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_done,
    output logic [INDEX_W-1:0] tag_a,
    output logic [INDEX_W-1:0] tag_a_2,
    output logic [TAG_W:0]     tag_d,
    output logic               tag_we,
    input  logic [TAG_W:0]     tag_spo,
    input  logic [TAG_W:0]     tag_spo_2,
    output state_e             state_dbg
);
    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cpu_addr_q, inv_addr_q;
    logic [ADDR_W-1:0]  cmp_addr_1, cmp_addr_2;
    logic [INDEX_W-1:0] flush_cnt_q;
    logic               rsp_hit_q, rsp_hit_d;
    logic               hit_1, hit_2;
    logic               cpu_accept, inv_accept;
    logic               unused_offset_bits;

    // valid/ready: a request transfers on the rising edge where both are high; ready is
    // only raised in IDLE outside reset, and an inval request withdraws CPU readiness.
    assign cpu_accept = cpu_req_valid && cpu_req_ready;
    assign inv_accept = inval_valid && inval_ready;

`ifdef TAGV_READ_DELAY_EN
    assign cmp_addr_1 = cpu_addr_q;
    assign cmp_addr_2 = inv_addr_q;
`else
    assign cmp_addr_1 = cpu_req_addr;
    assign cmp_addr_2 = inval_addr;
`endif

    cache_tag_cmp u_cmp_1 (.entry(tag_spo),   .tag(addr_tag(cmp_addr_1)), .hit(hit_1));
    cache_tag_cmp u_cmp_2 (.entry(tag_spo_2), .tag(addr_tag(cmp_addr_2)), .hit(hit_2));

    assign unused_offset_bits = ^{cpu_req_addr[OFFSET_W-1:0], inval_addr[OFFSET_W-1:0],
                                  cpu_addr_q[OFFSET_W-1:0], inv_addr_q[OFFSET_W-1:0]};
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cpu_addr_q  <= '0;
            inv_addr_q  <= '0;
            flush_cnt_q <= '0;
            rsp_hit_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_hit_q <= rsp_hit_d;
            if (cpu_accept) cpu_addr_q <= cpu_req_addr;
            if (inv_accept) inv_addr_q <= inval_addr;
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + INDEX_W'(1) : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        rsp_hit_d = rsp_hit_q;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (inval_valid) begin
`ifdef TAGV_READ_DELAY_EN
                    state_d = INV_PROBE;
`else
                    state_d = hit_2 ? INV_WR : IDLE;
`endif
                end else if (cpu_req_valid) begin
`ifdef TAGV_READ_DELAY_EN
                    state_d = LOOKUP;
`else
                    state_d   = hit_1 ? RESP : MISS_REQ;
                    rsp_hit_d = hit_1;
`endif
                end
            end
            LOOKUP: begin
                state_d   = hit_1 ? RESP : MISS_REQ;
                rsp_hit_d = hit_1;
            end
            INV_PROBE: state_d = hit_2 ? INV_WR : IDLE;
            MISS_REQ:  if (mem_gnt)  state_d = MISS_WAIT;
            MISS_WAIT: if (mem_done) state_d = REFILL_WR;
            REFILL_WR: begin
                state_d   = RESP;
                rsp_hit_d = 1'b0;
            end
            INV_WR:    state_d = IDLE;
            RESP:      state_d = IDLE;
            FLUSH:     if (flush_cnt_q == '1) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_req_ready = rst_n && (state_q == IDLE) && !flush && !inval_valid;
        inval_ready   = rst_n && (state_q == IDLE) && !flush;
        cpu_rsp_valid = (state_q == RESP);
        cpu_rsp_hit   = (state_q == RESP) && rsp_hit_q;
        flush_busy    = (state_q == FLUSH);
        mem_req       = (state_q == MISS_REQ);
        mem_addr      = {cpu_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        tag_we        = 1'b0;
        tag_d         = '0;
        tag_a         = addr_index(cpu_req_addr);
        tag_a_2       = (state_q == INV_PROBE) ? addr_index(inv_addr_q) : addr_index(inval_addr);
        case (state_q)
            FLUSH: begin
                tag_a  = flush_cnt_q;
                tag_we = 1'b1;
            end
            REFILL_WR: begin
                tag_a  = addr_index(cpu_addr_q);
                tag_we = 1'b1;
                tag_d  = {1'b1, addr_tag(cpu_addr_q)};
            end
            INV_WR: begin
                tag_a  = addr_index(inv_addr_q);
                tag_we = 1'b1;
            end
            LOOKUP:  tag_a = addr_index(cpu_addr_q);
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cache_tagv_ctrl.sv
// Bench for cache_tagv_ctrl: tag array model, cache-content reference model, write scoreboard.
module tb_cache_tagv_ctrl;
    import cache_pkg::*;

`ifdef TAGV_READ_DELAY_EN
    localparam int HIT_LAT = 2;
    localparam int IDLE_BASE = 2;
`else
    localparam int HIT_LAT = 1;
    localparam int IDLE_BASE = 1;
`endif

    typedef enum int {OP_LOOKUP, OP_INVAL, OP_FLUSH} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] addr;
        bit          also_cpu;
        bit          exp;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cpu_req_valid = 1'b0, inval_valid = 1'b0, flush = 1'b0;
    logic mem_gnt = 1'b0, mem_done = 1'b0;
    logic [31:0] cpu_req_addr = '0, inval_addr = '0;
    logic cpu_req_ready, cpu_rsp_valid, cpu_rsp_hit, inval_ready, flush_busy, mem_req, tag_we;
    logic [31:0] mem_addr;
    logic [4:0] tag_a, tag_a_2;
    logic [23:0] tag_d, tag_spo, tag_spo_2;
    state_e state_dbg;

    int n_tests = 0, n_fail = 0;
    logic [28:0] exp_q[$];
    bit mv[32];
    logic [22:0] mt[32];

    always #5 clk = ~clk;

    cache_tagv_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_hit(cpu_rsp_hit),
        .inval_valid(inval_valid), .inval_ready(inval_ready), .inval_addr(inval_addr),
        .flush(flush), .flush_busy(flush_busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_done(mem_done),
        .tag_a(tag_a), .tag_a_2(tag_a_2), .tag_d(tag_d), .tag_we(tag_we),
        .tag_spo(tag_spo), .tag_spo_2(tag_spo_2), .state_dbg(state_dbg)
    );

    // Tag array: all entries start invalid
    logic [23:0] tv_mem [32] = '{default: '0};
    logic [4:0] rd_a_q = '0, rd_a2_q = '0;
    always @(posedge clk) begin
        if (tag_we) tv_mem[tag_a] <= tag_d;
        rd_a_q  <= tag_a;
        rd_a2_q <= tag_a_2;
    end
`ifdef TAGV_READ_DELAY_EN
    assign tag_spo   = tv_mem[rd_a_q];
    assign tag_spo_2 = tv_mem[rd_a2_q];
`else
    assign tag_spo   = tv_mem[tag_a];
    assign tag_spo_2 = tv_mem[tag_a_2];
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write scoreboard: every tag write must match the head of exp_q
    always @(negedge clk) begin
        if (tag_we === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tag_write: unexpected write a=%0d d=0x%0h", tag_a, tag_d);
            end else begin
                logic [28:0] e;
                e = exp_q.pop_front();
                if ({tag_a, tag_d} !== e) begin
                    n_fail++;
                    $display("FAIL tag_write: got a=%0d d=0x%0h expected a=%0d d=0x%0h",
                             tag_a, tag_d, e[28:24], e[23:0]);
                end
            end
        end
    end

    // Reference model of cache contents
    function automatic bit m_lookup(input logic [31:0] a);
        bit hit;
        hit = mv[a[8:4]] && (mt[a[8:4]] == a[31:9]);
        if (!hit) begin
            mv[a[8:4]] = 1'b1;
            mt[a[8:4]] = a[31:9];
        end
        return hit;
    endfunction

    function automatic bit m_inval(input logic [31:0] a);
        bit match;
        match = mv[a[8:4]] && (mt[a[8:4]] == a[31:9]);
        if (match) mv[a[8:4]] = 1'b0;
        return match;
    endfunction

    function automatic void m_flush();
        for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    endfunction

    task automatic do_lookup(input logic [31:0] addr, input bit exp_hit, input int gnt_dly,
                             input int done_dly, input bit spur_done);
        int cyc = 1, req_cyc = 0, gnt_cyc = 0, req_len = 0, rsp_cyc = 0;
        bit got = 0, seen_req = 0, gnt_given = 0, addr_bad = 0, rsp_hit = 0;
        if (!exp_hit) exp_q.push_back({addr[8:4], 1'b1, addr[31:9]});
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        #1 check("cpu_req_ready", cpu_req_ready, 1);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_addr  = $urandom();
        while (!got && cyc < 300) begin
            mem_gnt  = 1'b0;
            mem_done = 1'b0;
            #1;
            if (cpu_rsp_valid) begin
                got = 1; rsp_hit = cpu_rsp_hit; rsp_cyc = cyc;
            end
            if (mem_req) begin
                if (!seen_req) begin seen_req = 1; req_cyc = cyc; end
                req_len++;
                if (mem_addr !== {addr[31:4], 4'h0}) addr_bad = 1;
                if (cyc - req_cyc == gnt_dly) begin
                    mem_gnt = 1'b1; gnt_given = 1; gnt_cyc = cyc;
                end else if (spur_done) begin
                    mem_done = 1'b1;
                end
            end else if (gnt_given && cyc - gnt_cyc == done_dly) begin
                mem_done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        mem_gnt  = 1'b0;
        mem_done = 1'b0;
        #1;
        check("rsp_seen", got, 1);
        check("rsp_one_cycle", cpu_rsp_valid, 0);
        if (got) begin
            check("rsp_hit", rsp_hit, exp_hit);
            check("mem_req_seen", seen_req, !exp_hit);
            if (exp_hit) begin
                check("hit_latency", rsp_cyc, HIT_LAT);
            end else begin
                check("mem_req_len", req_len, gnt_dly + 1);
                check("mem_addr_stable", addr_bad, 0);
                check("miss_latency", rsp_cyc, HIT_LAT + gnt_dly + done_dly + 2);
            end
        end
    endtask

    task automatic do_inval(input logic [31:0] addr, input bit also_cpu, input bit exp_match);
        int cyc = 1;
        if (exp_match) exp_q.push_back({addr[8:4], 24'h0});
        @(negedge clk);
        inval_valid   = 1'b1;
        inval_addr    = addr;
        cpu_req_valid = also_cpu;
        cpu_req_addr  = addr;
        #1 check("inval_ready", inval_ready, 1);
        if (also_cpu) check("cpu_ready_vs_inval", cpu_req_ready, 0);
        @(negedge clk);
        inval_valid   = 1'b0;
        cpu_req_valid = 1'b0;
        inval_addr    = $urandom();
        #1;
        while (!inval_ready && cyc < 20) begin
            @(negedge clk);
            #1 cyc++;
        end
        check("inval_idle_cycles", cyc, IDLE_BASE + int'(exp_match));
    endtask

    task automatic do_flush();
        int busy = 0, rdy_bad = 0;
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), 24'h0});
        @(negedge clk);
        flush = 1'b1;
        #1 check("flush_cpu_ready", cpu_req_ready, 0);
        check("flush_inval_ready", inval_ready, 0);
        @(negedge clk);
        flush         = 1'b0;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h0000_1230;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (flush_busy) begin
                busy++;
                if (cpu_req_ready) rdy_bad++;
            end
            cpu_req_valid = flush_busy;
            flush = (c == 10);
            @(negedge clk);
        end
        flush = 1'b0;
        cpu_req_valid = 1'b0;
        check("flush_busy_cycles", busy, 32);
        check("flush_ready_low", rdy_bad, 0);
    endtask

    task automatic run_vec(input vec_t v);
        case (v.op)
            OP_LOOKUP: begin
                void'(m_lookup(v.addr));
                do_lookup(v.addr, v.exp, $urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            end
            OP_INVAL: begin
                void'(m_inval(v.addr));
                do_inval(v.addr, v.also_cpu, v.exp);
            end
            default: begin
                m_flush();
                do_flush();
            end
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        logic [31:0] a;
        int bad;
        tbl[0]  = '{OP_LOOKUP, 32'h0000_1230, 0, 1};
        tbl[1]  = '{OP_INVAL,  32'h0000_1234, 1, 1};
        tbl[2]  = '{OP_LOOKUP, 32'h0000_1230, 0, 0};
        tbl[3]  = '{OP_INVAL,  32'h0000_3230, 0, 0};
        tbl[4]  = '{OP_LOOKUP, 32'h0000_123C, 0, 1};
        tbl[5]  = '{OP_LOOKUP, 32'h0000_5670, 0, 0};
        tbl[6]  = '{OP_LOOKUP, 32'h0000_5678, 0, 1};
        tbl[7]  = '{OP_LOOKUP, 32'h0000_5470, 0, 0};
        tbl[8]  = '{OP_LOOKUP, 32'h0000_5670, 0, 0};
        tbl[9]  = '{OP_INVAL,  32'h0000_5470, 0, 0};
        tbl[10] = '{OP_FLUSH,  32'h0,         0, 0};
        tbl[11] = '{OP_LOOKUP, 32'h0000_1230, 0, 0};
        tbl[12] = '{OP_LOOKUP, 32'hFFFF_FFF0, 0, 0};
        tbl[13] = '{OP_LOOKUP, 32'hFFFF_FFFC, 0, 1};
        tbl[14] = '{OP_INVAL,  32'hFFFF_FFF8, 0, 1};
        tbl[15] = '{OP_LOOKUP, 32'hFFFF_FFF0, 0, 0};
        m_flush();

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_cpu_ready", cpu_req_ready, 0);
        check("rst_inval_ready", inval_ready, 0);
        check("rst_outputs", {cpu_rsp_valid, cpu_rsp_hit, flush_busy, mem_req, tag_we}, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;

        // First miss: grant 2 cycles into the request, done 3 after grant, early done ignored
        void'(m_lookup(32'h0000_1230));
        do_lookup(32'h0000_1230, 1'b0, 2, 3, 1'b1);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset while waiting for refill data abandons the refill
        a = 32'h0000_ABC0;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        begin
            int c = 0;
            #1;
            while (!mem_req && c < 10) begin @(negedge clk); #1 c++; end
        end
        check("rmid_mem_req", mem_req, 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1 check("rmid_req_drop", mem_req, 0);
        check("rmid_wait_state", 32'(state_dbg), 32'(MISS_WAIT));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        mem_done = 1'b1;
        #1 check("rmid_state", 32'(state_dbg), 32'(IDLE));
        check("rmid_outputs", {mem_req, tag_we, cpu_rsp_valid}, 0);
        @(negedge clk);
        mem_done = 1'b0;
        repeat (3) begin
            #1 check("rmid_no_rsp", {cpu_rsp_valid, tag_we}, 0);
            @(negedge clk);
        end
        check("rmid_model_miss", m_lookup(a), 0);
        do_lookup(a, 1'b0, 1, 1, 1'b0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            int r;
            r = $urandom_range(0, 99);
            a = {23'(32'h155 * $urandom_range(0, 3)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15))};
            if (r < 70) begin
                bit h;
                h = m_lookup(a);
                do_lookup(a, h, $urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            end else if (r < 96) begin
                bit m;
                m = m_inval(a);
                do_inval(a, 1'($urandom_range(0, 1)), m);
            end else begin
                m_flush();
                do_flush();
            end
        end

        repeat (2) @(negedge clk);
        check("writes_outstanding", exp_q.size(), 0);
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (tv_mem[i] !== (mv[i] ? {1'b1, mt[i]} : 24'h0)) bad++;
        check("array_contents", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
